// File: rtl/serial_pkg.sv
// Shared definitions for the serial front end and the pattern-detector FSMs.
package serial_pkg;

    // Serializer control states
    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    // Default word width and idle line level
    localparam int unsigned DEFAULT_WIDTH    = 8;
    localparam logic        DEFAULT_IDLE_BIT = 1'b0;

    // Bits needed to count 0..n-1 (at least 1)
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready,
// one bit per clock out on inbits. A one-word hold buffer keeps
// consecutive words contiguous on the serial side.
module word_serializer
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = DEFAULT_IDLE_BIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             inbits,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int unsigned    CW   = clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic [WIDTH-1:0] hold, hold_d;
    logic             hold_full, hold_full_d;
    logic             inbits_d, bit_valid_d, frame_start_d, busy_d;
    logic             load_en;
    logic [WIDTH-1:0] load_word;
    logic             xfer;

    // Bit that leaves first from a word in the configured order
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its leading bit consumed
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign in_ready = reset && !hold_full;
    assign xfer     = in_valid && in_ready;

    // Next-state and next-output decode; outputs are registered so the
    // detector sees one clean value per cycle. The register always holds
    // the bits not yet driven, so the output bit is precomputed here.
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        shreg_d       = shreg;
        hold_d        = hold;
        hold_full_d   = hold_full;
        inbits_d      = IDLE_BIT;
        bit_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        load_en       = 1'b0;
        load_word     = '0;
        case (state)
            S_IDLE: begin
                if (xfer) begin
                    load_en   = 1'b1;
                    load_word = in_data;
                end
            end
            S_SHIFT: begin
                if (cnt == LAST) begin
                    if (hold_full) begin
                        load_en     = 1'b1;
                        load_word   = hold;
                        hold_full_d = 1'b0;
                    end else if (xfer) begin
                        load_en   = 1'b1;
                        load_word = in_data;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    shreg_d     = shift_word(shreg);
                    inbits_d    = lead_bit(shreg);
                    bit_valid_d = 1'b1;
                    cnt_d       = cnt + CW'(1);
                    if (xfer) begin
                        hold_d      = in_data;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load_en) begin
            state_d       = S_SHIFT;
            cnt_d         = '0;
            shreg_d       = shift_word(load_word);
            inbits_d      = lead_bit(load_word);
            bit_valid_d   = 1'b1;
            frame_start_d = 1'b1;
        end
        busy_d = (state_d == S_SHIFT) || hold_full_d;
    end

    // State, datapath and output registers; reset discards everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            shreg       <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            inbits      <= IDLE_BIT;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            shreg       <= shreg_d;
            hold        <= hold_d;
            hold_full   <= hold_full_d;
            inbits      <= inbits_d;
            bit_valid   <= bit_valid_d;
            frame_start <= frame_start_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer (MSB-first and LSB-first instances).
module tb_word_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data, in_data_b;
    logic       in_valid, in_valid_b;
    logic       in_ready, inbits, bit_valid, frame_start, busy;
    logic       in_ready_b, inbits_b, bit_valid_b, frame_start_b, busy_b;

    int checks = 0;
    int errors = 0;

    logic s_ready, s_bit, s_valid, s_fs, s_busy;
    logic [7:0] stim_q[$];

    always #5 clk = ~clk;

    word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .inbits(inbits), .bit_valid(bit_valid),
        .frame_start(frame_start), .busy(busy)
    );

    word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .inbits(inbits_b), .bit_valid(bit_valid_b),
        .frame_start(frame_start_b), .busy(busy_b)
    );

    // Reference: i-th serial bit of a word in the given order
    function automatic logic ref_bit(input logic [7:0] w, input int i, input bit msb);
        return msb ? w[7 - i] : w[i];
    endfunction

    // Drive one cycle on the selected instance, report handshake, sample after the edge
    task automatic step(input bit sel, input logic v, input logic [7:0] d, output bit acc);
        if (!sel) begin in_valid = v; in_data = d; end
        else begin in_valid_b = v; in_data_b = d; end
        #1;
        acc = sel ? (in_valid_b && in_ready_b) : (in_valid && in_ready);
        @(posedge clk);
        #1;
        s_ready = sel ? in_ready_b    : in_ready;
        s_bit   = sel ? inbits_b      : inbits;
        s_valid = sel ? bit_valid_b   : bit_valid;
        s_fs    = sel ? frame_start_b : frame_start;
        s_busy  = sel ? busy_b        : busy;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 0; in_data = '0; in_valid_b = 0; in_data_b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_low got %b exp 0", in_ready); end
        checks++; if (bit_valid !== 1'b0 || inbits !== 1'b0 || busy !== 1'b0 || frame_start !== 1'b0) begin
            errors++; $display("FAIL rst_outputs got v%b b%b busy%b fs%b exp all 0", bit_valid, inbits, busy, frame_start); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || in_ready_b !== 1'b1) begin errors++; $display("FAIL rel_ready got %b/%b exp 1", in_ready, in_ready_b); end
        checks++; if (inbits !== 1'b0 || bit_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rel_idle got b%b v%b busy%b exp 0", inbits, bit_valid, busy); end
    endtask

    // Send one word from idle and check its 8 bits, frame marker and return to idle
    task automatic check_single(input logic [7:0] w, input string name);
        bit acc;
        step(0, 1'b1, w, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL %s_accept got %b exp 1", name, acc); end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step(0, 1'b0, 8'h00, acc);
            checks++; if (s_valid !== 1'b1 || s_bit !== ref_bit(w, i, 1'b1)) begin
                errors++; $display("FAIL %s_bit%0d got v%b b%b exp v1 b%b", name, i, s_valid, s_bit, ref_bit(w, i, 1'b1)); end
            checks++; if (s_fs !== (i == 0)) begin
                errors++; $display("FAIL %s_fs%0d got %b exp %b", name, i, s_fs, (i == 0)); end
        end
        step(0, 1'b0, 8'h00, acc);
        checks++; if (s_valid !== 1'b0 || s_bit !== 1'b0 || s_busy !== 1'b0 || s_fs !== 1'b0) begin
            errors++; $display("FAIL %s_idle got v%b b%b busy%b fs%b exp 0", name, s_valid, s_bit, s_busy, s_fs); end
    endtask

    task automatic test_single_word();
        check_single(8'hC3, "single");
    endtask

    // Feed stim_q with in_valid held (or random gaps) and compare the stream to the model
    task automatic run_stream(input bit sel, input bit msb, input bit contig, input bit expect_stall,
                              input int unsigned max_gap, input string name);
        logic [7:0] pend[$];
        logic exp_b[$];
        logic exp_f[$];
        int gap = 0, nbits = 0, run = 0, max_run = 0, total;
        bit saw_stall = 0, done = 0, acc;
        logic v, eb, ef;
        logic [7:0] d, w;
        pend = stim_q;
        total = 8 * pend.size();
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            v = (pend.size() > 0) && (gap == 0);
            d = v ? pend[0] : 8'h00;
            if (gap > 0) gap--;
            step(sel, v, d, acc);
            if (v && !acc) saw_stall = 1;
            if (acc) begin
                w = pend.pop_front();
                for (int i = 0; i < 8; i++) begin
                    exp_b.push_back(ref_bit(w, i, msb));
                    exp_f.push_back(i == 0);
                end
                if (max_gap > 0) gap = $urandom_range(max_gap, 0);
            end
            if (s_valid === 1'b1) begin
                nbits++; run++;
                if (run > max_run) max_run = run;
                checks++;
                if (exp_b.size() == 0) begin
                    errors++; $display("FAIL %s_extra_bit got b%b exp none", name, s_bit);
                end else begin
                    eb = exp_b.pop_front(); ef = exp_f.pop_front();
                    if (s_bit !== eb || s_fs !== ef) begin
                        errors++; $display("FAIL %s_bit%0d got b%b fs%b exp b%b fs%b", name, nbits - 1, s_bit, s_fs, eb, ef);
                    end
                end
            end else begin
                run = 0;
                checks++; if (s_fs !== 1'b0 || s_bit !== 1'b0) begin
                    errors++; $display("FAIL %s_idle_line got b%b fs%b exp 0", name, s_bit, s_fs); end
                if (pend.size() == 0 && exp_b.size() == 0) done = 1;
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL %s_timeout got pending %0d exp 0", name, exp_b.size() + 8 * pend.size()); end
        checks++; if (nbits != total) begin errors++; $display("FAIL %s_bitcount got %0d exp %0d", name, nbits, total); end
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end got %b exp 0", name, s_busy); end
        if (contig) begin
            checks++; if (max_run != total) begin errors++; $display("FAIL %s_contig got %0d exp %0d", name, max_run, total); end
        end
        if (expect_stall) begin
            checks++; if (!saw_stall) begin errors++; $display("FAIL %s_stall got 0 exp 1", name); end
        end
    endtask

    task automatic test_streaming();
        stim_q = '{8'hA5, 8'h3C, 8'hFF};
        run_stream(0, 1'b1, 1'b1, 1'b1, 0, "stream");
    endtask

    task automatic test_bit_order();
        stim_q = '{8'h01};
        run_stream(1, 1'b0, 1'b1, 1'b0, 0, "lsb");
        stim_q = '{8'h01, 8'h80, 8'h96};
        run_stream(1, 1'b0, 1'b1, 1'b1, 0, "lsb_stream");
    endtask

    task automatic test_bypass();
        bit acc;
        logic [7:0] a = 8'h5A, b = 8'hE1;
        step(0, 1'b1, a, acc);
        for (int i = 1; i < 8; i++) step(0, 1'b0, 8'h00, acc);
        checks++; if (s_valid !== 1'b1 || s_bit !== ref_bit(a, 7, 1'b1) || s_ready !== 1'b1) begin
            errors++; $display("FAIL bypass_last got v%b b%b rdy%b exp v1 b%b rdy1", s_valid, s_bit, s_ready, ref_bit(a, 7, 1'b1)); end
        step(0, 1'b1, b, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL bypass_accept got %b exp 1", acc); end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step(0, 1'b0, 8'h00, acc);
            checks++; if (s_valid !== 1'b1 || s_bit !== ref_bit(b, i, 1'b1) || s_fs !== (i == 0)) begin
                errors++; $display("FAIL bypass_bit%0d got v%b b%b fs%b exp v1 b%b fs%b", i, s_valid, s_bit, s_fs, ref_bit(b, i, 1'b1), (i == 0)); end
        end
        step(0, 1'b0, 8'h00, acc);
        checks++; if (s_valid !== 1'b0 || s_busy !== 1'b0) begin errors++; $display("FAIL bypass_idle got v%b busy%b exp 0", s_valid, s_busy); end
    endtask

    task automatic test_mid_reset();
        bit acc;
        step(0, 1'b1, 8'hF0, acc);
        step(0, 1'b1, 8'h0F, acc);
        checks++; if (acc !== 1'b1 || s_ready !== 1'b0 || s_busy !== 1'b1) begin
            errors++; $display("FAIL mrst_hold got acc%b rdy%b busy%b exp 1 0 1", acc, s_ready, s_busy); end
        step(0, 1'b0, 8'h00, acc);
        reset = 1'b0;
        #1;
        checks++; if (bit_valid !== 1'b0 || inbits !== 1'b0 || busy !== 1'b0 || frame_start !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL mrst_async got v%b b%b busy%b fs%b rdy%b exp 0", bit_valid, inbits, busy, frame_start, in_ready); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        step(0, 1'b0, 8'h00, acc);
        checks++; if (s_valid !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL mrst_release got v%b rdy%b exp 0 1", s_valid, s_ready); end
        check_single(8'h81, "after_rst");
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            stim_q = {};
            for (int k = 0; k < 5; k++) stim_q.push_back(8'($urandom));
            run_stream(0, 1'b1, 1'b0, 1'b0, 10, "rand_gap");
            stim_q = {};
            for (int k = 0; k < 4; k++) stim_q.push_back(8'($urandom));
            run_stream(r[0], ~r[0], 1'b1, 1'b1, 0, "rand_b2b");
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_streaming();
        test_bit_order();
        test_bypass();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
